// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues fetch requests to instruction
// memory and registers the fetched word into the IF/ID pipeline register.
// A resolved taken branch from decode redirects the PC and squashes IF/ID.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        uncond_br,
    input  logic [63:0] br_pc,
    input  logic [31:0] br_instr,
    output logic [31:0] if_id_instr,
    output logic [63:0] if_id_pc,
    output logic        if_id_valid
);

    typedef enum logic [0:0] {
        ST_BOOT  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t      state_r;
    logic [63:0] pc_r;
    logic        req_r;
    logic [31:0] if_id_instr_r;
    logic [63:0] if_id_pc_r;
    logic        if_id_valid_r;

    logic [63:0] br_target_s;
    logic [63:0] pc_inc_s;
    logic        unused_s;

    // Branch target: B format carries a 26-bit word offset, CB/B.cond a
    // 19-bit word offset in bits 23:5; both are sign-extended and scaled by 4.
    function automatic logic [63:0] branch_target(
        input logic [63:0] base,
        input logic [31:0] instr,
        input logic        uncond
    );
        logic [63:0] offset;
        if (uncond) begin
            offset = {{36{instr[25]}}, instr[25:0], 2'b00};
        end else begin
            offset = {{43{instr[23]}}, instr[23:5], 2'b00};
        end
        return base + offset;
    endfunction

    // Next-PC candidates: redirect target and sequential successor.
    always_comb begin
        br_target_s = branch_target(br_pc, br_instr, uncond_br);
        pc_inc_s    = pc_r + 64'd4;
    end

    // The opcode bits of the branch word play no part in target formation.
    assign unused_s = ^br_instr[31:26];

    // Fetch address follows the PC directly so memory sees it this cycle.
    assign imem_addr   = pc_r;
    assign imem_req    = req_r;
    assign if_id_instr = if_id_instr_r;
    assign if_id_pc    = if_id_pc_r;
    assign if_id_valid = if_id_valid_r;

    // Fetch FSM: PC and IF/ID update with redirect > stall > capture > wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_BOOT;
            req_r         <= 1'b0;
            pc_r          <= RESET_PC;
            if_id_instr_r <= BUBBLE;
            if_id_pc_r    <= 64'd0;
            if_id_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    // One idle cycle out of reset; all pipeline inputs ignored.
                    state_r       <= ST_FETCH;
                    req_r         <= 1'b1;
                    pc_r          <= RESET_PC;
                    if_id_instr_r <= BUBBLE;
                    if_id_pc_r    <= 64'd0;
                    if_id_valid_r <= 1'b0;
                end
                ST_FETCH: begin
                    state_r <= ST_FETCH;
                    req_r   <= 1'b1;
                    if (br_taken) begin
                        // Wrong-path word in flight is dropped; one bubble follows.
                        pc_r          <= br_target_s;
                        if_id_instr_r <= BUBBLE;
                        if_id_pc_r    <= 64'd0;
                        if_id_valid_r <= 1'b0;
                    end else if (stall) begin
                        // Freeze; the same word is fetched again once released.
                        pc_r          <= pc_r;
                        if_id_instr_r <= if_id_instr_r;
                        if_id_pc_r    <= if_id_pc_r;
                        if_id_valid_r <= if_id_valid_r;
                    end else if (imem_ready) begin
                        pc_r          <= pc_inc_s;
                        if_id_instr_r <= imem_data;
                        if_id_pc_r    <= pc_r;
                        if_id_valid_r <= 1'b1;
                    end else begin
                        // Memory not ready: keep asking for the same address.
                        pc_r          <= pc_r;
                        if_id_instr_r <= BUBBLE;
                        if_id_pc_r    <= 64'd0;
                        if_id_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_BOOT;
                    req_r         <= 1'b0;
                    pc_r          <= RESET_PC;
                    if_id_instr_r <= BUBBLE;
                    if_id_pc_r    <= 64'd0;
                    if_id_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
